// File: rtl/dac_seq_pkg.sv
// Shared state encoding and default widths for the DAC mute/mode sequencer.
package dac_seq_pkg;

  localparam int DW_DEF         = 24;
  localparam int RAMP_LOG2_DEF  = 8;
  localparam int SETTLE_CNT_DEF = 64;

  typedef enum logic [2:0] {
    ST_MUTED     = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_RUN       = 3'd3,
    ST_RAMP_DOWN = 3'd4
  } seq_state_t;

endpackage

// File: rtl/dac_gain_mult.sv
// Registered signed sample x unsigned gain multiply, arithmetic (floor) shift back to DW bits.
module dac_gain_mult #(
  parameter int DW    = 24,
  parameter int GW    = 9,
  parameter int SHIFT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic [GW-1:0] gain,
  output logic [DW-1:0] dout
);

  localparam int PW = DW + GW + 1;

  logic signed [PW-1:0] din_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;
  logic [DW-1:0]        dout_reg;

  // gain is unsigned, so it is zero-extended; the sample is sign-extended
  assign din_ext  = $signed({{(PW-DW){din[DW-1]}}, din});
  assign gain_ext = $signed({{(PW-GW){1'b0}}, gain});
  assign product  = din_ext * gain_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg <= '0;
    end else if (en) begin
      dout_reg <= DW'(product >>> SHIFT);
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/dac_mute_sequencer.sv
// Soft mute/unmute gain ramp in front of the DAC; ISI/MIS mode bits only move while fully muted.
module dac_mute_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int RAMP_LOG2  = RAMP_LOG2_DEF,
  parameter int SETTLE_CNT = SETTLE_CNT_DEF
) (
  input  logic          m_clk,
  input  logic          rst_n,
  input  logic          sample_en,
  input  logic [DW-1:0] din,
  input  logic          isi_req,
  input  logic          mis_req,
  input  logic          mute_req,
  output logic [DW-1:0] dout,
  output logic          isi_sel,
  output logic          mis_sel,
  output logic          muted,
  output logic          ramping
);

  localparam int              GW   = RAMP_LOG2 + 1;
  localparam int              CW   = (SETTLE_CNT > 1) ? $clog2(SETTLE_CNT) : 1;
  localparam logic [GW-1:0]   FULL = GW'(1) << RAMP_LOG2;

  seq_state_t    state_reg, state_next;
  logic [GW-1:0] gain_reg, gain_next, gain_inc;
  logic [CW-1:0] settle_cnt_reg, settle_cnt_next;
  logic          isi_sel_reg, isi_sel_next;
  logic          mis_sel_reg, mis_sel_next;
  logic          mismatch;

  assign mismatch = (isi_req != isi_sel_reg) | (mis_req != mis_sel_reg);
  assign gain_inc = gain_reg + GW'(1);

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_MUTED;
      gain_reg       <= '0;
      settle_cnt_reg <= '0;
      isi_sel_reg    <= 1'b0;
      mis_sel_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gain_reg       <= gain_next;
      settle_cnt_reg <= settle_cnt_next;
      isi_sel_reg    <= isi_sel_next;
      mis_sel_reg    <= mis_sel_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    gain_next       = gain_reg;
    settle_cnt_next = settle_cnt_reg;
    isi_sel_next    = isi_sel_reg;
    mis_sel_next    = mis_sel_reg;
    if (sample_en) begin
      unique case (state_reg)
        ST_MUTED: begin
          // a pending mode change wins over unmute so the switch always happens at zero gain
          if (mismatch) begin
            isi_sel_next    = isi_req;
            mis_sel_next    = mis_req;
            settle_cnt_next = CW'(SETTLE_CNT - 1);
            state_next      = ST_SETTLE;
          end else if (!mute_req) begin
            state_next = ST_RAMP_UP;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_reg == '0) state_next = ST_MUTED;
          else                      settle_cnt_next = settle_cnt_reg - CW'(1);
        end
        ST_RAMP_UP: begin
          if (mute_req | mismatch) begin
            state_next = ST_RAMP_DOWN;
          end else begin
            gain_next = gain_inc;
            if (gain_inc == FULL) state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (mute_req | mismatch) state_next = ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          // a ramp down always completes; withdrawn requests are looked at again in MUTED
          if (gain_reg <= GW'(1)) begin
            gain_next  = '0;
            state_next = ST_MUTED;
          end else begin
            gain_next = gain_reg - GW'(1);
          end
        end
        default: begin
          gain_next  = '0;
          state_next = ST_MUTED;
        end
      endcase
    end
  end

  dac_gain_mult #(
    .DW    (DW),
    .GW    (GW),
    .SHIFT (RAMP_LOG2)
  ) u_gain_mult (
    .clk   (m_clk),
    .rst_n (rst_n),
    .en    (sample_en),
    .din   (din),
    .gain  (gain_reg),
    .dout  (dout)
  );

  assign isi_sel = isi_sel_reg;
  assign mis_sel = mis_sel_reg;
  assign muted   = (state_reg == ST_MUTED) || (state_reg == ST_SETTLE);
  assign ramping = (state_reg == ST_RAMP_UP) || (state_reg == ST_RAMP_DOWN);

endmodule

// File: tb/tb_dac_mute_sequencer.sv
// Scoreboard bench for dac_mute_sequencer: the driver queues expected outputs, a monitor checks each sample.
module tb_dac_mute_sequencer;

  logic        m_clk;
  logic        rst_n;
  logic        sample_en;
  logic [23:0] din;
  logic        isi_req;
  logic        mis_req;
  logic        mute_req;
  logic [23:0] dout;
  logic        isi_sel;
  logic        mis_sel;
  logic        muted;
  logic        ramping;

  typedef struct packed {
    logic [23:0] dout;
    logic        isi;
    logic        mis;
    logic        muted;
    logic        ramping;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_txn = 0;
  logic fire_q = 1'b0;

  dac_mute_sequencer dut (
    .m_clk     (m_clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .din       (din),
    .isi_req   (isi_req),
    .mis_req   (mis_req),
    .mute_req  (mute_req),
    .dout      (dout),
    .isi_sel   (isi_sel),
    .mis_sel   (mis_sel),
    .muted     (muted),
    .ramping   (ramping)
  );

  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // A DUT output is presented one clock after each sample_en; check it on the following negedge.
  always @(posedge m_clk) fire_q <= sample_en & rst_n;

  always @(negedge m_clk) begin
    if (fire_q) begin
      n_vec++;
      n_txn++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got dout=%h with no expectation queued", dout);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn %0d dout=%h isi=%b mis=%b muted=%b ramping=%b", n_txn, dout, isi_sel, mis_sel,
                 muted, ramping);
        if (dout !== mon_e.dout || isi_sel !== mon_e.isi || mis_sel !== mon_e.mis ||
            muted !== mon_e.muted || ramping !== mon_e.ramping) begin
          n_err++;
          $display("FAIL sample_%0d: got dout=%h isi=%b mis=%b muted=%b ramping=%b, want dout=%h isi=%b mis=%b muted=%b ramping=%b",
                   n_txn, dout, isi_sel, mis_sel, muted, ramping,
                   mon_e.dout, mon_e.isi, mon_e.mis, mon_e.muted, mon_e.ramping);
        end
      end
    end
  end

  task automatic check_val(input string nm, input logic [23:0] act, input logic [23:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // One sample: drive on a negedge, queue the expected response, then one idle cycle.
  task automatic do_sample(input logic [23:0] d, input logic mute, input logic isi, input logic mis,
                           input logic [23:0] ed, input logic ei, input logic em,
                           input logic emu, input logic er);
    exp_t e;
    din       = d;
    mute_req  = mute;
    isi_req   = isi;
    mis_req   = mis;
    e.dout    = ed;
    e.isi     = ei;
    e.mis     = em;
    e.muted   = emu;
    e.ramping = er;
    exp_q.push_back(e);
    sample_en = 1'b1;
    @(negedge m_clk);
    sample_en = 1'b0;
    @(negedge m_clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge m_clk);
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sample_en = 1'b0;
    din       = '0;
    mute_req  = 1'b0;
    isi_req   = 1'b0;
    mis_req   = 1'b0;
    repeat (3) @(negedge m_clk);
    check_val("reset_dout", dout, 24'h000000);
    check_val("reset_isi", {23'd0, isi_sel}, 24'd0);
    check_val("reset_mis", {23'd0, mis_sel}, 24'd0);
    check_val("reset_muted", {23'd0, muted}, 24'd1);
    check_val("reset_ramping", {23'd0, ramping}, 24'd0);
    rst_n = 1'b1;
    @(negedge m_clk);

    // Unmute from reset: MUTED -> RAMP_UP, then 256 ramp samples to RUN.
    do_sample(24'h100000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 256; g++)
      do_sample(24'h100000, 1'b0, 1'b0, 1'b0, 24'(g * 4096), 1'b0, 1'b0, 1'b0, g != 255);
    do_sample(24'h100000, 1'b0, 1'b0, 1'b0, 24'h100000, 1'b0, 1'b0, 1'b0, 1'b0);
    // Most negative sample at unity gain passes through unchanged.
    do_sample(24'h800000, 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mode switch from RUN: ramp down, switch isi at zero gain, settle, ramp up.
    do_sample(24'h100000, 1'b0, 1'b1, 1'b0, 24'h100000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int g = 256; g >= 1; g--)
      do_sample(24'h100000, 1'b0, 1'b1, 1'b0, 24'(g * 4096), 1'b0, 1'b0, g == 1, g != 1);
    do_sample(24'h100000, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 63; c >= 0; c--)
      do_sample(24'h100000, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_sample(24'h100000, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 256; g++)
      do_sample(24'h100000, 1'b0, 1'b1, 1'b0, 24'(g * 4096), 1'b1, 1'b0, 1'b0, g != 255);
    do_sample(24'h100000, 1'b0, 1'b1, 1'b0, 24'h100000, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Asynchronous reset while in RUN at full gain takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_run_dout", dout, 24'h000000);
    check_val("rst_run_isi", {23'd0, isi_sel}, 24'd0);
    check_val("rst_run_muted", {23'd0, muted}, 24'd1);
    check_val("rst_run_ramping", {23'd0, ramping}, 24'd0);
    isi_req = 1'b0;
    @(negedge m_clk);
    rst_n = 1'b1;
    @(negedge m_clk);

    // Abort ramp-up at gain 100; din=-1 at gain 1 floors to -1.
    do_sample(24'h100000, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 100; g++)
      do_sample((g == 1) ? 24'hFFFFFF : 24'h100000, 1'b0, 1'b0, 1'b0,
                (g == 1) ? 24'hFFFFFF : 24'(g * 4096), 1'b0, 1'b0, 1'b0, 1'b1);
    do_sample(24'h100000, 1'b1, 1'b0, 1'b0, 24'h064000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int g = 100; g >= 1; g--)
      do_sample(24'h100000, 1'b1, 1'b0, 1'b0, 24'(g * 4096), 1'b0, 1'b0, g == 1, g != 1);
    do_sample(24'h100000, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mode change while held muted: settle then stay muted; idle cycles change nothing.
    do_sample(24'h100000, 1'b1, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 63; c >= 0; c--) begin
      do_sample(24'h100000, 1'b1, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0);
      if (c % 16 == 0) begin
        din      = 24'h7FFFFF;
        mute_req = 1'b0;
        isi_req  = 1'b1;
        mis_req  = 1'b0;
        @(negedge m_clk);
        check_val("idle_dout", dout, 24'h000000);
        check_val("idle_isi", {23'd0, isi_sel}, 24'd0);
        check_val("idle_mis", {23'd0, mis_sel}, 24'd1);
        check_val("idle_muted", {23'd0, muted}, 24'd1);
      end
    end
    repeat (3)
      do_sample(24'h100000, 1'b1, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
